// File: rtl/aes_inv_cipher_core.sv
// aes_inv_cipher_core: iterative AES-128 decryption, one round per clock.
// Round keys are fetched by index from an external store and used in the same cycle.
module aes_inv_cipher_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  output logic [3:0]   key_round_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, DONE = 2'd3} state_t;

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
    return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8]; i = 4*column + row.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv_sbox_byte(s[8*i +: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [3:0][7:0] m9, mb, md, me;
    logic [7:0] a, x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a     = col[31 - 8*i -: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  state_t       state_r, state_s;
  logic [127:0] st_r, st_s;
  logic [3:0]   rnd_r, rnd_s;
  logic [127:0] out_text_r, out_text_s;
  logic         out_valid_r, out_valid_s;
  logic         in_ready_r, in_ready_s;
  logic         busy_r, busy_s;
  logic [3:0]   key_idx_r, key_idx_s;
  logic [127:0] sub_s;

  assign sub_s = inv_sub_bytes(inv_shift_rows(st_r));

  // Next-state, datapath and state-decoded handshake outputs.
  always_comb begin
    state_s     = state_r;
    st_s        = st_r;
    rnd_s       = rnd_r;
    out_text_s  = out_text_r;
    out_valid_s = out_valid_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          st_s    = in_text ^ round_key;
          rnd_s   = 4'd9;
          state_s = ROUND;
        end else begin
          state_s = IDLE;
        end
      end
      ROUND: begin
        st_s = inv_mix_columns(sub_s ^ round_key);
        if (rnd_r == 4'd1) begin
          state_s = FINAL;
        end else begin
          rnd_s = rnd_r - 4'd1;
        end
      end
      FINAL: begin
        out_text_s  = sub_s ^ round_key;
        out_valid_s = 1'b1;
        state_s     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase

    // Outputs are registered copies of the decode of the next state.
    in_ready_s = (state_s == IDLE);
    busy_s     = (state_s == ROUND) || (state_s == FINAL);
    case (state_s)
      IDLE:    key_idx_s = 4'd10;
      ROUND:   key_idx_s = rnd_s;
      default: key_idx_s = 4'd0;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      st_r        <= 128'd0;
      rnd_r       <= 4'd0;
      out_text_r  <= 128'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      key_idx_r   <= 4'd10;
    end else begin
      state_r     <= state_s;
      st_r        <= st_s;
      rnd_r       <= rnd_s;
      out_text_r  <= out_text_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
      busy_r      <= busy_s;
      key_idx_r   <= key_idx_s;
    end
  end

  assign in_ready      = in_ready_r;
  assign busy          = busy_r;
  assign key_round_idx = key_idx_r;
  assign out_valid     = out_valid_r;
  assign out_text      = out_text_r;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Self-checking bench for aes_inv_cipher_core: FIPS-197 vectors plus random blocks
// against a byte-array AES model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes_inv_cipher_core;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_text, round_key, out_text;
  logic [3:0]   key_round_idx;
  logic [127:0] rk_mem [0:10];
  logic [7:0]   sbox [0:255];
  logic [7:0]   isbox [0:255];
  int           n_cmp = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  assign round_key = (key_round_idx <= 4'd10) ? rk_mem[key_round_idx] : 128'd0;

  aes_inv_cipher_core dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_text(in_text), .key_round_idx(key_round_idx), .round_key(round_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'd0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'd0, a} << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'd0;
      for (int y = 1; y < 256; y++) if (x != 0 && gf_mul(x[7:0], y[7:0]) == 8'd1) inv = y[7:0];
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = x[7:0];
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'd0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Textbook inverse cipher on a 16-byte array, byte index = 4*column + row.
  function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [127:0] pt;
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ rk_mem[10][127 - 8*i -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c - r + 4) % 4) + r];
      for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ rk_mem[rd][127 - 8*i -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[4*c + r];
          for (int r = 0; r < 4; r++)
            s[4*c + r] = gf_mul(8'h0e, t[r]) ^ gf_mul(8'h0b, t[(r+1)%4]) ^
                         gf_mul(8'h0d, t[(r+2)%4]) ^ gf_mul(8'h09, t[(r+3)%4]);
        end
      end
    end
    for (int i = 0; i < 16; i++) pt[127 - 8*i -: 8] = s[i];
    return pt;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_text = 128'd0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (key_round_idx !== 4'd10) begin n_fail++; $display("FAIL rst_key_idx: got %0d want 10", key_round_idx); end
    n_cmp++; if (out_text !== 128'd0) begin n_fail++; $display("FAIL rst_out_text: got %h want 0", out_text); end
    reset = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    // reset and in_valid together: nothing may be accepted
    in_valid = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({busy, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_vs_valid: got busy/in_ready %b want 01", {busy, in_ready}); end
  endtask

  task automatic test_fips_c1();
    int lat;
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    in_text = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 30) begin tick(); lat++; end
    n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL c1_latency: got %0d want 10", lat); end
    n_cmp++; if (out_text !== 128'h00112233445566778899aabbccddeeff) begin n_fail++; $display("FAIL c1_text: got %h want 00112233445566778899aabbccddeeff", out_text); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL c1_release: got %b want 0", out_valid); end
  endtask

  task automatic test_fips_b();
    int lat;
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    in_text = 128'h3925841d02dc09fbdc118597196a0b32; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 30) begin tick(); lat++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b_timeout: out_valid %b want 1", out_valid); end
    n_cmp++; if (out_text !== 128'h3243f6a8885a308d313198a2e0370734) begin n_fail++; $display("FAIL b_text: got %h want 3243f6a8885a308d313198a2e0370734", out_text); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_key_trace();
    logic [127:0] ct;
    int busy_cnt;
    ct = rand128(); load_key(rand128());
    in_text = ct; in_valid = 1'b1;
    n_cmp++; if (key_round_idx !== 4'd10) begin n_fail++; $display("FAIL trace_idx0: got %0d want 10", key_round_idx); end
    tick();
    in_valid = 1'b0; busy_cnt = 0;
    for (int k = 1; k <= 13; k++) begin
      busy_cnt += (busy === 1'b1) ? 1 : 0;
      if (k <= 11) begin
        n_cmp++;
        if (key_round_idx !== ((k <= 10) ? 4'(10 - k) : 4'd0)) begin
          n_fail++; $display("FAIL trace_idx%0d: got %0d want %0d", k, key_round_idx, (k <= 10) ? 10 - k : 0);
        end
      end
      tick();
    end
    n_cmp++; if (busy_cnt !== 10) begin n_fail++; $display("FAIL trace_busy: got %0d cycles want 10", busy_cnt); end
    n_cmp++; if (out_text !== model_decrypt(ct)) begin n_fail++; $display("FAIL trace_text: got %h want %h", out_text, model_decrypt(ct)); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (key_round_idx !== 4'd10) begin n_fail++; $display("FAIL trace_idle_idx: got %0d want 10", key_round_idx); end
  endtask

  task automatic test_backpressure();
    logic [127:0] ct_a, ct_b, held;
    int lat;
    logic bad;
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    ct_a = rand128(); ct_b = rand128();
    in_text = ct_a; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_text = ct_b; lat = 0;
    while (!out_valid && lat < 30) begin tick(); lat++; end
    held = out_text; bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_text !== held || in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    n_cmp++; if (held !== model_decrypt(ct_a)) begin n_fail++; $display("FAIL bp_text_a: got %h want %h", held, model_decrypt(ct_a)); end
    n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got disturbed=%b want 0", bad); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL bp_idle: got %b want 010", {out_valid, in_ready, busy}); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept_b: busy %b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 30) begin tick(); lat++; end
    n_cmp++; if (out_text !== model_decrypt(ct_b)) begin n_fail++; $display("FAIL bp_text_b: got %h want %h", out_text, model_decrypt(ct_b)); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    in_text = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL mid_rst_state: got %b want 010", {out_valid, in_ready, busy}); end
    n_cmp++; if (key_round_idx !== 4'd10) begin n_fail++; $display("FAIL mid_rst_idx: got %0d want 10", key_round_idx); end
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin tick(); if (out_valid !== 1'b0) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ghost: got out_valid seen=%b want 0", seen); end
    in_valid = 1'b1; tick(); in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 30) begin tick(); lat++; end
    n_cmp++; if (out_text !== 128'h00112233445566778899aabbccddeeff) begin n_fail++; $display("FAIL mid_rst_c1: got %h want 00112233445566778899aabbccddeeff", out_text); end
    // reset and out_ready together in DONE
    reset = 1'b1; out_ready = 1'b1; tick(); reset = 1'b0; out_ready = 1'b0;
    n_cmp++; if ({out_valid, out_text} !== {1'b0, 128'd0}) begin n_fail++; $display("FAIL rst_vs_ready: got valid %b text %h want 0/0", out_valid, out_text); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct, exp_pt, got;
    logic acc, done, dup;
    int n_out;
    n_out = 0; dup = 1'b0;
    for (int blk = 0; blk < 100; blk++) begin
      load_key(rand128());
      ct = rand128(); exp_pt = model_decrypt(ct);
      in_text = ct; in_valid = 1'b1; acc = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid) dup = 1'b1;
        if (in_ready) acc = 1'b1;
        tick();
      end
      in_valid = 1'b0; done = 1'b0; got = 128'd0;
      for (int w = 0; w < 200 && !done; w++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin got = out_text; done = 1'b1; n_out++; end
        tick();
      end
      n_cmp++;
      if (!acc || !done || got !== exp_pt) begin
        n_fail++; $display("FAIL b2b_%0d: acc %b done %b got %h want %h", blk, acc, done, got, exp_pt);
      end
    end
    out_ready = 1'b0;
    if (out_valid) dup = 1'b1;
    n_cmp++; if (n_out !== 100) begin n_fail++; $display("FAIL b2b_count: got %0d outputs want 100", n_out); end
    n_cmp++; if (dup !== 1'b0) begin n_fail++; $display("FAIL b2b_dup: got extra out_valid %b want 0", dup); end
  endtask

  initial begin
    for (int r = 0; r <= 10; r++) rk_mem[r] = 128'd0;
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_key_trace();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
